// File: rtl/pipe_reg.sv
// Two-entry skid-buffer pipeline register with registered in_ready/out_valid and a synchronous flush.
// Optional stall counter output enabled by defining PIPE_REG_STALL_CNT_EN.
module pipe_reg #(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RST_DATA = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
`ifdef PIPE_REG_STALL_CNT_EN
  output logic [15:0]      stall_cnt,
`endif
  input  logic             flush
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             take_in;
  logic             take_out;

  // in_ready is a flop mirroring "skid empty", so there is no ready path through the stage.
  assign take_in  = in_valid && in_ready;
  assign take_out = out_valid && out_ready;
  assign out_data = main_q;

  // State, storage and handshake flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= EMPTY;
      main_q    <= RST_DATA;
      skid_q    <= RST_DATA;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      out_valid <= (state_d != EMPTY);
      in_ready  <= (state_d != TWO);
    end
  end

  // Next-state and next-storage; flush overrides every transfer.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RST_DATA;
      skid_d  = RST_DATA;
    end else begin
      case (state_q)
        EMPTY: begin
          if (take_in) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (take_in && take_out) begin
            main_d = in_data;
          end else if (take_in) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (take_out) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (take_out) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

`ifdef PIPE_REG_STALL_CNT_EN
  // Saturating count of back-pressured cycles; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 16'd0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// Directed bench for pipe_reg: vector table for handshake/flush behaviour plus async reset
// and (when PIPE_REG_STALL_CNT_EN is defined) stall counter sequences.
module tb_pipe_reg;

  localparam int unsigned W  = 32;
  localparam logic [W-1:0] RD = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         flush;
`ifdef PIPE_REG_STALL_CNT_EN
  logic [15:0]  stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pipe_reg #(.WIDTH(W), .RST_DATA(RD)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
`ifdef PIPE_REG_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .flush     (flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         fl;
    logic         exp_ov;
    logic         exp_ir;
    logic         chk_d;
    logic [W-1:0] exp_d;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic iv, input logic [W-1:0] d, input logic ordy,
                              input logic fl, input logic ov, input logic ir,
                              input logic cd, input logic [W-1:0] ed);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.exp_ov = ov; v.exp_ir = ir; v.chk_d = cd; v.exp_d = ed;
    return v;
  endfunction

  initial begin
    // single transfer, latency one cycle
    vecs[0]  = mk(1, 32'h0000_1234, 1, 0, 1, 1, 1, 32'h0000_1234);
    vecs[1]  = mk(0, 32'h0,         1, 0, 0, 1, 0, 32'h0);
    // streaming at full rate
    vecs[2]  = mk(1, 32'd1, 1, 0, 1, 1, 1, 32'd1);
    vecs[3]  = mk(1, 32'd2, 1, 0, 1, 1, 1, 32'd2);
    vecs[4]  = mk(1, 32'd3, 1, 0, 1, 1, 1, 32'd3);
    vecs[5]  = mk(1, 32'd4, 1, 0, 1, 1, 1, 32'd4);
    vecs[6]  = mk(0, 32'd0, 1, 0, 0, 1, 0, 32'd0);
    // back-pressure into skid, then drain in order
    vecs[7]  = mk(1, 32'hA, 0, 0, 1, 1, 1, 32'hA);
    vecs[8]  = mk(1, 32'hB, 0, 0, 1, 0, 1, 32'hA);
    vecs[9]  = mk(1, 32'hC, 0, 0, 1, 0, 1, 32'hA);
    vecs[10] = mk(1, 32'hC, 1, 0, 1, 1, 1, 32'hB);
    vecs[11] = mk(1, 32'hC, 1, 0, 1, 1, 1, 32'hC);
    vecs[12] = mk(0, 32'h0, 1, 0, 0, 1, 0, 32'h0);
    // flush from TWO with a concurrent offer
    vecs[13] = mk(1, 32'hA, 0, 0, 1, 1, 1, 32'hA);
    vecs[14] = mk(1, 32'hB, 0, 0, 1, 0, 1, 32'hA);
    vecs[15] = mk(1, 32'hD, 0, 1, 0, 1, 1, RD);
    vecs[16] = mk(0, 32'h0, 1, 0, 0, 1, 1, RD);
    // flush from ONE with in & out both offered
    vecs[17] = mk(1, 32'h5, 0, 0, 1, 1, 1, 32'h5);
    vecs[18] = mk(1, 32'h6, 1, 1, 0, 1, 1, RD);
    // hold in ONE, then drain
    vecs[19] = mk(1, 32'h7, 0, 0, 1, 1, 1, 32'h7);
    vecs[20] = mk(0, 32'h0, 0, 0, 1, 1, 1, 32'h7);
    vecs[21] = mk(0, 32'h0, 1, 0, 0, 1, 0, 32'h0);

    reset = 1'b1;
    drive(0, '0, 0, 0);
    #12;
    chk("rst_out_valid", W'(out_valid), W'(1'b0));
    chk("rst_in_ready",  W'(in_ready),  W'(1'b1));
    chk("rst_out_data",  out_data,      RD);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      step();
      chk($sformatf("v%0d_out_valid", i), W'(out_valid), W'(vecs[i].exp_ov));
      chk($sformatf("v%0d_in_ready", i),  W'(in_ready),  W'(vecs[i].exp_ir));
      if (vecs[i].chk_d) chk($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_d);
    end

    // async reset between edges while in TWO
    drive(1, 32'h11, 0, 0); step();
    drive(1, 32'h22, 0, 0); step();
    chk("pre_rst_in_ready", W'(in_ready), W'(1'b0));
    #2 reset = 1'b1;
    #1;
    chk("async_out_valid", W'(out_valid), W'(1'b0));
    chk("async_in_ready",  W'(in_ready),  W'(1'b1));
    chk("async_out_data",  out_data,      RD);
    drive(0, '0, 1, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 32'h33, 1, 0);
    step();
    chk("post_rst_out_valid", W'(out_valid), W'(1'b1));
    chk("post_rst_out_data",  out_data,      32'h33);
    drive(0, '0, 1, 0);
    step();
    chk("post_rst_drain", W'(out_valid), W'(1'b0));

`ifdef PIPE_REG_STALL_CNT_EN
    reset = 1'b1;
    #3;
    chk("stall_rst", W'(stall_cnt), W'(16'd0));
    @(negedge clk);
    reset = 1'b0;
    drive(1, 32'h44, 0, 0); step();
    drive(0, '0, 0, 0);
    for (int i = 0; i < 5; i++) step();
    chk("stall_5", W'(stall_cnt), W'(16'd5));
    for (int i = 0; i < 70000; i++) @(posedge clk);
    #1;
    chk("stall_sat", W'(stall_cnt), W'(16'hFFFF));
    chk("stall_hold_data", out_data, 32'h44);
    drive(0, '0, 0, 1); step();
    drive(0, '0, 0, 0); step();
    chk("stall_flush", W'(stall_cnt), W'(16'hFFFF));
    #2 reset = 1'b1;
    #1;
    chk("stall_clear", W'(stall_cnt), W'(16'd0));
    @(negedge clk);
    reset = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 Parameter WIDTH, default 32, payload bit width (legal 1..1024).
REQ-002 Parameter RST_DATA, default 0, WIDTH-bit value loaded into every data register on reset and flush.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream has a payload on in_data.
REQ-006 in_data  input  WIDTH  upstream payload.
REQ-007 in_ready  output  1  stage can accept; registered, equals "skid entry empty".
REQ-008 out_valid  output  1  out_data holds a live payload; registered.
REQ-009 out_data  output  WIDTH  oldest held payload; driven directly from the main register.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 flush  input  1  synchronous kill of all held payloads (branch/exception bubble).

Function
REQ-012 Storage SHALL be two entries: main (drives out_data) and skid; state SHALL be EMPTY, ONE (main valid) or TWO (main+skid valid).
REQ-013 Transfer in SHALL occur on a cycle with in_valid && in_ready; transfer out on out_valid && out_ready.
REQ-014 EMPTY: in_valid -> ONE, main <= in_data; else stay EMPTY.
REQ-015 ONE: in & out -> ONE, main <= in_data; in only -> TWO, skid <= in_data; out only -> EMPTY; neither -> hold.
REQ-016 TWO: out_ready -> ONE, main <= skid; in_valid SHALL be ignored (in_ready=0); otherwise hold.
REQ-017 out_valid SHALL be 1 in ONE and TWO; in_ready SHALL be 0 only in TWO.
REQ-018 Latency SHALL be exactly one cycle from accepted input to out_valid with an empty stage; sustained throughput one payload/cycle while out_ready=1.
REQ-019 Payloads SHALL leave in acceptance order; none duplicated or dropped except by flush.
REQ-020 Held payloads SHALL remain bit-stable while out_valid && !out_ready.
REQ-021 flush SHALL have priority over all transfers: next state EMPTY, main and skid <= RST_DATA; an input offered in the flush cycle SHALL be discarded.
REQ-022 in_ready SHALL not depend combinationally on out_ready (no ready path through the stage).

Reset
REQ-023 While reset=1, regardless of clk: state EMPTY, out_valid=0, in_ready=1, main=skid=RST_DATA, out_data=RST_DATA.
REQ-024 Reset asserted mid-transfer SHALL discard all held payloads; first acceptance possible on first posedge after reset deassertion.

Configuration
REQ-025 Macro PIPE_REG_STALL_CNT_EN, when defined, SHALL add output stall_cnt (16 bits) counting cycles with out_valid && !out_ready, saturating at 16'hFFFF, cleared by reset only (not by flush).
REQ-026 Without PIPE_REG_STALL_CNT_EN the port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-027 Reset, then in_valid=1 in_data=32'h0000_1234 one cycle, out_ready=1 -> next cycle out_valid=1 out_data=32'h0000_1234, following cycle out_valid=0.
REQ-028 Stream 1,2,3,4 on consecutive cycles with out_ready=1 -> out_data 1,2,3,4 on consecutive cycles, in_ready constantly 1.
REQ-029 out_ready=0, offer 0xA then 0xB -> state TWO, in_ready=0, out_data=0xA; offered 0xC held off; raise out_ready -> outputs 0xA,0xB,0xC in order, none lost.
REQ-030 State TWO (0xA,0xB) plus flush=1 and in_valid=1 in_data=0xD -> next cycle out_valid=0, in_ready=1, out_data=RST_DATA; 0xD never appears.
REQ-031 Reset asserted asynchronously between clock edges in state TWO -> out_valid=0, in_ready=1 immediately, before next posedge.
REQ-032 With PIPE_REG_STALL_CNT_EN: hold out_valid=1 out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF; flush leaves it unchanged; reset clears to 0.
